// File: rtl/wb_dpram_ws_pkg.sv
// Shared definitions for the wait-stated dual-port Wishbone RAM.
// Contents: per-port FSM state encoding, wait counter width, bus widths and
// the address window check used by both port controllers.
package wb_dpram_ws_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } port_state_e;

    // Wide enough for a LATENCY-1 preload of up to 14.
    localparam int unsigned CntWidth = 4;
    localparam int unsigned DatWidth = 32;
    localparam int unsigned SelWidth = 4;

    // True when the address bits above the array size match the window base.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input int unsigned aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/wb_dpram_ws_if.sv
// Wishbone classic slave bundle for one port of wb_dpram_ws.
// Signals keep the memory's point of view: *_i are driven by the bus master,
// *_o by the memory.
//   addr_i  byte address (bits [1:0] ignored)   dat_i  write data
//   sel_i   byte enables                        we_i   write enable
//   cyc_i   bus cycle                           stb_i  strobe
//   dat_o   registered read data                ack_o  ack pulse
//   err_o   error pulse
// Modports: master (bus side), slave (memory side).
interface wb_dpram_ws_if;

    logic [31:0] addr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic        cyc_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output addr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  addr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o
    );

endinterface

// File: rtl/wb_dpram_ws_port_ctrl.sv
// Request sequencer for one Wishbone port of wb_dpram_ws.
// Holds the IDLE/WAIT/RESP FSM, the wait counter, the request latches and the
// window check, and tells the top level on which edge to perform the access.
//   clk, rst        clock, asynchronous active-high reset
//   cyc, stb, we    bus control
//   addr, sel,wdata request address, byte enables, write data
//   access          perform the array access on this edge
//   acc_word        word address of the access
//   acc_we, acc_sel, acc_wdata, acc_in_win  request attributes for the access
module wb_dpram_ws_port_ctrl
    import wb_dpram_ws_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned ADDR_WIDTH = 22,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc,
    input  logic                  stb,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [SelWidth-1:0]   sel,
    input  logic [DatWidth-1:0]   wdata,
    output logic                  access,
    output logic [ADDR_WIDTH-3:0] acc_word,
    output logic                  acc_we,
    output logic [SelWidth-1:0]   acc_sel,
    output logic [DatWidth-1:0]   acc_wdata,
    output logic                  acc_in_win
);

    if (LATENCY == 0 || LATENCY > 15) begin : gen_bad_latency
        $error("wb_dpram_ws_port_ctrl: LATENCY must be within 1..15");
    end
    if (ADDR_WIDTH < 3 || ADDR_WIDTH > 32) begin : gen_bad_addr_width
        $error("wb_dpram_ws_port_ctrl: ADDR_WIDTH must be within 3..32");
    end

    port_state_e           state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-3:0] word_q;
    logic                  we_q;
    logic [SelWidth-1:0]   sel_q;
    logic [DatWidth-1:0]   wdata_q;
    logic                  in_win_q;

    logic req;
    logic live_in_win;
    logic use_live;

    assign req         = cyc & stb;
    assign live_in_win = in_window(addr, BASE_ADDR, ADDR_WIDTH);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        access   = 1'b0;
        use_live = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        // Single-cycle latency: the access happens on the request
                        // edge itself, so it must use the live bus inputs.
                        access   = 1'b1;
                        use_live = 1'b1;
                        state_d  = StResp;
                    end else begin
                        cnt_d   = CntWidth'(LATENCY - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // Abort wins over a counter expiring on the same edge.
                if (!cyc) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                    if (cnt_d == '0) begin
                        access  = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        acc_word   = word_q;
        acc_we     = we_q;
        acc_sel    = sel_q;
        acc_wdata  = wdata_q;
        acc_in_win = in_win_q;
        if (use_live) begin
            acc_word   = addr[ADDR_WIDTH-1:2];
            acc_we     = we;
            acc_sel    = sel;
            acc_wdata  = wdata;
            acc_in_win = live_in_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            word_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            wdata_q  <= '0;
            in_win_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req) begin
                word_q   <= addr[ADDR_WIDTH-1:2];
                we_q     <= we;
                sel_q    <= sel;
                wdata_q  <= wdata;
                in_win_q <= live_in_win;
            end
        end
    end

endmodule

// File: rtl/wb_dpram_ws.sv
// Dual-port Wishbone RAM with programmable wait states.
// One read-only instruction port and one read/write data port share a single
// word-organised array (little-endian byte lanes, not cleared by reset).
// Each port answers after I_LATENCY / D_LATENCY cycles with a one-cycle
// ack, or err for addresses outside the BASE_ADDR window.
//   clk_i  clock            rst_i  asynchronous active-high reset
//   iwbs   instruction port (read-only; we_i ignored)
//   dwbs   data port (read/write with byte enables)
module wb_dpram_ws
    import wb_dpram_ws_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned I_LATENCY  = 1,
    parameter int unsigned D_LATENCY  = 1
) (
    input logic          clk_i,
    input logic          rst_i,
    wb_dpram_ws_if.slave iwbs,
    wb_dpram_ws_if.slave dwbs
);

    localparam int unsigned Words = 2 ** (ADDR_WIDTH - 2);

    logic [DatWidth-1:0] mem [Words];

    logic                  i_access, d_access;
    logic [ADDR_WIDTH-3:0] i_acc_word, d_acc_word;
    logic                  i_acc_we, d_acc_we;
    logic [SelWidth-1:0]   i_acc_sel, d_acc_sel;
    logic [DatWidth-1:0]   i_acc_wdata, d_acc_wdata;
    logic                  i_acc_in_win, d_acc_in_win;

    logic [DatWidth-1:0] i_dat_q, d_dat_q;
    logic                i_ack_q, d_ack_q;
    logic                i_err_q, d_err_q;

    wb_dpram_ws_port_ctrl #(
        .LATENCY   (I_LATENCY),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_iport (
        .clk       (clk_i),
        .rst       (rst_i),
        .cyc       (iwbs.cyc_i),
        .stb       (iwbs.stb_i),
        .we        (1'b0),
        .addr      (iwbs.addr_i),
        .sel       (iwbs.sel_i),
        .wdata     (iwbs.dat_i),
        .access    (i_access),
        .acc_word  (i_acc_word),
        .acc_we    (i_acc_we),
        .acc_sel   (i_acc_sel),
        .acc_wdata (i_acc_wdata),
        .acc_in_win(i_acc_in_win)
    );

    wb_dpram_ws_port_ctrl #(
        .LATENCY   (D_LATENCY),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_dport (
        .clk       (clk_i),
        .rst       (rst_i),
        .cyc       (dwbs.cyc_i),
        .stb       (dwbs.stb_i),
        .we        (dwbs.we_i),
        .addr      (dwbs.addr_i),
        .sel       (dwbs.sel_i),
        .wdata     (dwbs.dat_i),
        .access    (d_access),
        .acc_word  (d_acc_word),
        .acc_we    (d_acc_we),
        .acc_sel   (d_acc_sel),
        .acc_wdata (d_acc_wdata),
        .acc_in_win(d_acc_in_win)
    );

    // The instruction port never writes; its write-side attributes are dead.
    logic unused_iport;
    assign unused_iport = ^{iwbs.we_i, i_acc_we, i_acc_sel, i_acc_wdata};

    // Only the data port writes. Nonblocking update gives read-before-write
    // when the instruction port reads the same word on the same edge.
    always_ff @(posedge clk_i) begin
        if (d_access && d_acc_we && d_acc_in_win) begin
            for (int b = 0; b < SelWidth; b++) begin
                if (d_acc_sel[b]) begin
                    mem[d_acc_word][8*b +: 8] <= d_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i_dat_q <= '0;
            i_ack_q <= 1'b0;
            i_err_q <= 1'b0;
            d_dat_q <= '0;
            d_ack_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            i_ack_q <= i_access & i_acc_in_win;
            i_err_q <= i_access & ~i_acc_in_win;
            if (i_access) begin
                i_dat_q <= i_acc_in_win ? mem[i_acc_word] : '0;
            end

            d_ack_q <= d_access & d_acc_in_win;
            d_err_q <= d_access & ~d_acc_in_win;
            if (d_access) begin
                // Writes leave read data untouched; errors clear it.
                if (!d_acc_in_win) begin
                    d_dat_q <= '0;
                end else if (!d_acc_we) begin
                    d_dat_q <= mem[d_acc_word];
                end
            end
        end
    end

    assign iwbs.dat_o = i_dat_q;
    assign iwbs.ack_o = i_ack_q;
    assign iwbs.err_o = i_err_q;
    assign dwbs.dat_o = d_dat_q;
    assign dwbs.ack_o = d_ack_q;
    assign dwbs.err_o = d_err_q;

endmodule

// File: tb/tb_wb_dpram_ws.sv
// Self-checking bench for wb_dpram_ws (I_LATENCY=1, D_LATENCY=3, 64 KiB window).
// Directed timing scenarios followed by random traffic checked against an
// array model of the memory.
module tb_wb_dpram_ws;

    localparam int unsigned AW   = 16;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned IL   = 1;
    localparam int unsigned DL   = 3;

    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   checks = 0;

    logic [31:0] model [int unsigned];
    logic [31:0] exp_i_dat;
    logic [31:0] exp_d_dat;

    wb_dpram_ws_if iwb ();
    wb_dpram_ws_if dwb ();

    wb_dpram_ws #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .I_LATENCY (IL),
        .D_LATENCY (DL)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .iwbs (iwb),
        .dwbs (dwb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] port_out(input bit dport);
        return dport ? {dwb.ack_o, dwb.err_o, dwb.dat_o} : {iwb.ack_o, iwb.err_o, iwb.dat_o};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) m = m | (32'hFF << (8 * b));
        end
        return (old & ~m) | (nw & m);
    endfunction

    // Entered and left 1 time unit after a rising edge. lat counts edges to the
    // first ack/err (0 if none within the budget); tail samples one cycle later.
    task automatic xfer(input bit dport, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sel, output int lat,
                        output logic ack, output logic err, output logic [31:0] rd,
                        output logic tail);
        logic [33:0] o;
        lat = 0;
        ack = 1'b0;
        err = 1'b0;
        if (dport) begin
            dwb.addr_i = a; dwb.dat_i = wd; dwb.sel_i = sel; dwb.we_i = we;
            dwb.cyc_i = 1'b1; dwb.stb_i = 1'b1;
        end else begin
            iwb.addr_i = a; iwb.cyc_i = 1'b1; iwb.stb_i = 1'b1;
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            o = port_out(dport);
            if (o[33] || o[32]) begin
                lat = c;
                break;
            end
        end
        o   = port_out(dport);
        ack = o[33];
        err = o[32];
        rd  = o[31:0];
        if (dport) begin
            dwb.cyc_i = 1'b0; dwb.stb_i = 1'b0;
        end else begin
            iwb.cyc_i = 1'b0; iwb.stb_i = 1'b0;
        end
        @(posedge clk); #1;
        o    = port_out(dport);
        tail = o[33] | o[32];
    endtask

    task automatic do_op(input bit dport, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] sel,
                         output logic [31:0] rd);
        int          lat;
        logic        ack, err, tail;
        bit          inwin;
        int unsigned idx;
        logic [31:0] exp_rd;
        string       p;
        p     = $sformatf("%s %s %h", dport ? "d" : "i", (dport && we) ? "wr" : "rd", a);
        inwin = (a >> AW) == (BASE >> AW);
        idx   = (a % (32'd1 << AW)) / 4;
        xfer(dport, we, a, wd, sel, lat, ack, err, rd, tail);
        if (!inwin) begin
            exp_rd = 32'h0;
        end else if (dport && we) begin
            model[idx] = merge(model.exists(idx) ? model[idx] : 32'h0, wd, sel);
            exp_rd     = exp_d_dat;
        end else begin
            exp_rd = model[idx];
        end
        if (dport) exp_d_dat = exp_rd;
        else exp_i_dat = exp_rd;
        chk({p, " latency"}, lat, dport ? DL : IL);
        chk({p, " ack"}, {31'h0, ack}, {31'h0, inwin});
        chk({p, " err"}, {31'h0, err}, {31'h0, !inwin});
        chk({p, " dat_o"}, rd, exp_rd);
        chk({p, " pulse width"}, {31'h0, tail}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int          acks [$];
        bit          seen;
        bit          dp;
        logic        we;
        logic [31:0] a;

        rst = 1'b1;
        iwb.addr_i = '0; iwb.dat_i = '0; iwb.sel_i = '0; iwb.we_i = 1'b0;
        iwb.cyc_i = 1'b0; iwb.stb_i = 1'b0;
        dwb.addr_i = '0; dwb.dat_i = '0; dwb.sel_i = '0; dwb.we_i = 1'b0;
        dwb.cyc_i = 1'b0; dwb.stb_i = 1'b0;
        exp_i_dat = 32'h0;
        exp_d_dat = 32'h0;
        #1;
        chk("reset i ack", {31'h0, iwb.ack_o}, 32'h0);
        chk("reset i err", {31'h0, iwb.err_o}, 32'h0);
        chk("reset i dat", iwb.dat_o, 32'h0);
        chk("reset d ack", {31'h0, dwb.ack_o}, 32'h0);
        chk("reset d err", {31'h0, dwb.err_o}, 32'h0);
        chk("reset d dat", dwb.dat_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Preload through the data port.
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, rd);
        do_op(1'b1, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF, rd);
        do_op(1'b1, 1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 4'hF, rd);
        do_op(1'b1, 1'b1, 32'h8000_0010, 32'h0123_4567, 4'hF, rd);
        do_op(1'b1, 1'b1, 32'h8000_FFFC, 32'hCAFE_F00D, 4'hF, rd);
        do_op(1'b1, 1'b1, 32'h8000_0100, 32'h0000_0000, 4'hF, rd);

        // Both ports read word 0 in the same cycle; sel=0 must not mask the read.
        iwb.addr_i = BASE; iwb.cyc_i = 1'b1; iwb.stb_i = 1'b1;
        dwb.addr_i = BASE; dwb.we_i = 1'b0; dwb.sel_i = 4'h0;
        dwb.cyc_i = 1'b1; dwb.stb_i = 1'b1;
        @(posedge clk); #1;
        chk("lat i ack at k+1", {31'h0, iwb.ack_o}, 32'h1);
        chk("lat i dat", iwb.dat_o, 32'hDEAD_BEEF);
        chk("lat d no ack at k+1", {31'h0, dwb.ack_o}, 32'h0);
        iwb.cyc_i = 1'b0; iwb.stb_i = 1'b0;
        @(posedge clk); #1;
        chk("lat i ack one cycle", {31'h0, iwb.ack_o}, 32'h0);
        chk("lat d no ack at k+2", {31'h0, dwb.ack_o}, 32'h0);
        @(posedge clk); #1;
        chk("lat d ack at k+3", {31'h0, dwb.ack_o}, 32'h1);
        chk("lat d dat", dwb.dat_o, 32'hDEAD_BEEF);
        dwb.cyc_i = 1'b0; dwb.stb_i = 1'b0;
        @(posedge clk); #1;
        chk("lat d ack one cycle", {31'h0, dwb.ack_o}, 32'h0);
        exp_i_dat = 32'hDEAD_BEEF;
        exp_d_dat = 32'hDEAD_BEEF;

        // Byte-lane write.
        do_op(1'b1, 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0101, rd);
        do_op(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, rd);
        chk("byte write result", rd, 32'h11BB_33DD);

        // Out-of-window accesses.
        do_op(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, rd);
        do_op(1'b1, 1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, rd);
        do_op(1'b1, 1'b0, 32'h8000_FFFC, 32'h0, 4'hF, rd);
        chk("err write left array", rd, 32'hCAFE_F00D);
        do_op(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, rd);

        // Abort a data write after one cycle in WAIT.
        dwb.addr_i = 32'h8000_0008; dwb.dat_i = 32'h0; dwb.sel_i = 4'hF;
        dwb.we_i = 1'b1; dwb.cyc_i = 1'b1; dwb.stb_i = 1'b1;
        @(posedge clk); #1;
        dwb.cyc_i = 1'b0; dwb.stb_i = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (dwb.ack_o || dwb.err_o) seen = 1'b1;
        end
        chk("abort no response", {31'h0, seen}, 32'h0);
        do_op(1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'hF, rd);
        chk("abort word intact", rd, 32'hA5A5_A5A5);

        // Strobe held for back-to-back reads.
        dwb.addr_i = BASE; dwb.we_i = 1'b0; dwb.sel_i = 4'hF;
        dwb.cyc_i = 1'b1; dwb.stb_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (dwb.ack_o) acks.push_back(c);
            if (acks.size() == 3) break;
        end
        dwb.cyc_i = 1'b0; dwb.stb_i = 1'b0;
        chk("b2b ack count", acks.size(), 32'd3);
        if (acks.size() == 3) begin
            chk("b2b first ack", acks[0], 32'd3);
            chk("b2b spacing 1", acks[1] - acks[0], 32'd4);
            chk("b2b spacing 2", acks[2] - acks[1], 32'd4);
        end
        chk("b2b dat", dwb.dat_o, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("b2b ack drops", {31'h0, dwb.ack_o}, 32'h0);
        exp_d_dat = 32'hDEAD_BEEF;

        // Same-edge instruction read and data write of one word.
        dwb.addr_i = 32'h8000_0100; dwb.dat_i = 32'h5555_5555; dwb.sel_i = 4'hF;
        dwb.we_i = 1'b1; dwb.cyc_i = 1'b1; dwb.stb_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        iwb.addr_i = 32'h8000_0100; iwb.cyc_i = 1'b1; iwb.stb_i = 1'b1;
        @(posedge clk); #1;
        chk("coll i ack", {31'h0, iwb.ack_o}, 32'h1);
        chk("coll d ack", {31'h0, dwb.ack_o}, 32'h1);
        chk("coll i old word", iwb.dat_o, 32'h0);
        iwb.cyc_i = 1'b0; iwb.stb_i = 1'b0;
        dwb.cyc_i = 1'b0; dwb.stb_i = 1'b0;
        @(posedge clk); #1;
        model[32'h40] = 32'h5555_5555;
        exp_i_dat = 32'h0;
        do_op(1'b0, 1'b0, 32'h8000_0100, 32'h0, 4'h0, rd);
        chk("coll new word", rd, 32'h5555_5555);

        // Random traffic over a preloaded region.
        for (int n = 0; n < 16; n++) begin
            do_op(1'b1, 1'b1, 32'h8000_0200 + 32'(4 * n), $urandom, 4'hF, rd);
        end
        for (int n = 0; n < 40; n++) begin
            dp = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            a  = 32'h8000_0200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if ((a >> AW) == (BASE >> AW)) a = a ^ 32'h4000_0000;
            end
            do_op(dp, we, a, $urandom, 4'($urandom_range(0, 15)), rd);
        end

        // Reset during a data write in WAIT.
        do_op(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd);
        do_op(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, rd);
        dwb.addr_i = 32'h8000_0010; dwb.dat_i = 32'hFFFF_FFFF; dwb.sel_i = 4'hF;
        dwb.we_i = 1'b1; dwb.cyc_i = 1'b1; dwb.stb_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        dwb.cyc_i = 1'b0; dwb.stb_i = 1'b0;
        #1;
        chk("rst async i dat", iwb.dat_o, 32'h0);
        chk("rst async d dat", dwb.dat_o, 32'h0);
        chk("rst async i ack", {31'h0, iwb.ack_o}, 32'h0);
        chk("rst async d ack", {31'h0, dwb.ack_o}, 32'h0);
        chk("rst async i err", {31'h0, iwb.err_o}, 32'h0);
        chk("rst async d err", {31'h0, dwb.err_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (dwb.ack_o || dwb.err_o) seen = 1'b1;
        end
        chk("rst no late ack", {31'h0, seen}, 32'h0);
        exp_i_dat = 32'h0;
        exp_d_dat = 32'h0;
        do_op(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, rd);
        chk("rst word intact", rd, 32'h0123_4567);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
